serial_frame_tx: RTL and testbench

//  Parallel-to-serial framer feeding the serial bit input x of the sequence-detector FSM.

---
 rtl/serial_frame_tx.sv | 134 +++++++++++++
 tb/tb_serial_frame_tx.sv | 132 +++++++++++++
 2 files changed

// File: rtl/serial_frame_tx.sv
// Parallel-to-serial framer: WIDTH-bit words in over valid/ready, shifted out MSB-first on x.
// Define SERIAL_PARITY_EN to append an even-parity bit to every frame.
module serial_frame_tx #(
  parameter int   WIDTH    = 8,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             x,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

`ifdef SERIAL_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_e;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_e;
`endif

  state_e           state_q, state_d;
  // The MSB goes straight to x at acceptance, so only the remaining WIDTH-1 bits are held.
  logic [WIDTH-2:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             x_q, x_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             accept;
`ifdef SERIAL_PARITY_EN
  logic             parity_q, parity_d;
`endif

  // The final frame bit is on x exactly when done_q is set.
  assign load_ready = (state_q == IDLE) | done_q;
  assign accept     = load_valid & load_ready;

  always_comb begin
    // NOTE: every signal gets a hold default first, so no path leaves one unassigned and no latch is inferred.
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    x_d      = x_q;
    busy_d   = busy_q;
    done_d   = done_q;
`ifdef SERIAL_PARITY_EN
    parity_d = parity_q;
`endif
    if (accept) begin
      state_d  = SHIFT;
      shreg_d  = load_data[WIDTH-2:0];
      cnt_d    = '0;
      x_d      = load_data[WIDTH-1];
      busy_d   = 1'b1;
      done_d   = 1'b0;
`ifdef SERIAL_PARITY_EN
      parity_d = ^load_data;
`endif
    end else begin
      unique case (state_q)
        SHIFT: begin
          if (cnt_q == LAST_IDX) begin
`ifdef SERIAL_PARITY_EN
            state_d = PARITY;
            x_d     = parity_q;
            done_d  = 1'b1;
`else
            state_d = IDLE;
            x_d     = IDLE_BIT;
            busy_d  = 1'b0;
            done_d  = 1'b0;
`endif
          end else begin
            x_d     = shreg_q[WIDTH-2];
            shreg_d = shreg_q << 1;
            cnt_d   = cnt_q + CW'(1);
`ifndef SERIAL_PARITY_EN
            done_d  = (cnt_q == LAST_IDX - CW'(1));
`endif
          end
        end
`ifdef SERIAL_PARITY_EN
        PARITY: begin
          state_d = IDLE;
          x_d     = IDLE_BIT;
          busy_d  = 1'b0;
          done_d  = 1'b0;
        end
`endif
        default: begin
          state_d = IDLE;
          x_d     = IDLE_BIT;
          busy_d  = 1'b0;
          done_d  = 1'b0;
        end
      endcase
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      // NOTE: the shift register is cleared too, so a discarded frame leaves no stale payload behind.
      shreg_q  <= '0;
      cnt_q    <= '0;
      x_q      <= IDLE_BIT;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SERIAL_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
      x_q      <= x_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef SERIAL_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign x    = x_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Self-checking bench for serial_frame_tx: two instances (IDLE_BIT=0 and 1) share the stimulus
// and are compared each cycle against a queue-of-line-bits reference model.
module tb_serial_frame_tx;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] load_data = '0;
  logic         load_valid = 1'b0;
  logic         load_ready0, x0, busy0, done0;
  logic         load_ready1, x1, busy1, done1;

  int checks = 0;
  int errors = 0;
  bit primed = 1'b0;

  // Bits still to appear on the line; element 0 is the bit on x this cycle.
  bit line_q[$];

  always #5 clk = ~clk;

  serial_frame_tx #(.WIDTH(W), .IDLE_BIT(1'b0)) dut0 (
    .clk(clk), .reset(reset), .load_data(load_data), .load_valid(load_valid),
    .load_ready(load_ready0), .x(x0), .busy(busy0), .done(done0)
  );

  serial_frame_tx #(.WIDTH(W), .IDLE_BIT(1'b1)) dut1 (
    .clk(clk), .reset(reset), .load_data(load_data), .load_valid(load_valid),
    .load_ready(load_ready1), .x(x1), .busy(busy1), .done(done1)
  );

  task automatic check(input string tag, input logic observed, input logic expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic push_frame(input logic [W-1:0] w);
    for (int i = W - 1; i >= 0; i--) line_q.push_back(w[i]);
`ifdef SERIAL_PARITY_EN
    line_q.push_back(^w);
`endif
  endtask

  // One clock cycle: ready is checked before the edge, registered outputs #1 after it.
  task automatic step(input logic r, input logic v, input logic [W-1:0] d);
    bit acc;
    bit exp_x0, exp_x1, exp_busy, exp_done, exp_ready;
    reset = r;
    load_valid = v;
    load_data = d;
    @(negedge clk);
    exp_ready = (line_q.size() <= 1);
    if (primed) begin
      check("load_ready0", load_ready0, exp_ready);
      check("load_ready1", load_ready1, exp_ready);
    end
    @(posedge clk);
    if (r) begin
      line_q.delete();
    end else begin
      acc = v && exp_ready;
      if (line_q.size() > 0) void'(line_q.pop_front());
      if (acc) push_frame(d);
    end
    primed = 1'b1;
    #1;
    exp_busy = (line_q.size() > 0);
    exp_done = (line_q.size() == 1);
    exp_x0   = exp_busy ? line_q[0] : 1'b0;
    exp_x1   = exp_busy ? line_q[0] : 1'b1;
    check("x0", x0, exp_x0);
    check("x1", x1, exp_x1);
    check("busy0", busy0, exp_busy);
    check("busy1", busy1, exp_busy);
    check("done0", done0, exp_done);
    check("done1", done1, exp_done);
  endtask

  initial begin
    // Reset for two cycles, then settle in idle.
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    step(1'b0, 1'b0, '0);

    // Single word.
    step(1'b0, 1'b1, 8'hA5);
    repeat (11) step(1'b0, 1'b0, '0);

    // Back-to-back with valid held high: the second word is taken on the final-bit cycle.
    step(1'b0, 1'b1, 8'hA5);
    repeat (12) step(1'b0, 1'b1, 8'hA5);
    repeat (8) step(1'b0, 1'b1, 8'h3C);
    repeat (4) step(1'b0, 1'b0, '0);

    // Word offered while busy is ignored.
    step(1'b0, 1'b1, 8'hFF);
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 8'h00);
    repeat (10) step(1'b0, 1'b0, '0);

    // Reset mid-frame, then a clean frame.
    step(1'b0, 1'b1, 8'hF0);
    step(1'b0, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 8'h81);
    repeat (11) step(1'b0, 1'b0, '0);

    // Parity corner: odd-weight word.
    step(1'b0, 1'b1, 8'h07);
    repeat (11) step(1'b0, 1'b0, '0);

    // Streaming zeros shows the idle level distinctly from payload on dut1.
    repeat (30) step(1'b0, 1'b1, 8'h00);
    repeat (4) step(1'b0, 1'b0, '0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), W'($urandom));
    end
    repeat (12) step(1'b0, 1'b0, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
